wishbone_slave_to_rtsnoc: RTL and testbench

CPU-side Wishbone slave that turns single-word bus reads and writes into RTSNoC command packets toward one fixed remote node. For reads it also waits for the response packet and returns its data to the bus. It is the upstream counterpart of the NoC-to-Wishbone master bridge. It uses the same packet format: the command word carries the type in its top 3 bits (0 = write, 1 = read) and the address in its low bits. A write sends the command word followed by one data word.

---
 rtl/wishbone_slave_to_rtsnoc.sv | 169 ++++++++++++++++
 tb/tb_wishbone_slave_to_rtsnoc.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wishbone_slave_to_rtsnoc.sv
// Wishbone slave that turns single-word reads and writes into RTSNoC command packets
// for one fixed remote bridge, and returns read responses (or a timeout error) to the bus.
module wishbone_slave_to_rtsnoc #(
    parameter int WB_ADDR_WIDTH     = 6,
    parameter int WB_NOC_DATA_WIDTH = 32,
    parameter int NOC_LOCAL_ADR     = 0,
    parameter int NOC_X             = 0,
    parameter int NOC_Y             = 0,
    parameter int NOC_LOCAL_ADR_TGT = 0,
    parameter int NOC_X_TGT         = 0,
    parameter int NOC_Y_TGT         = 0,
    parameter int SOC_SIZE_X        = 1,
    parameter int SOC_SIZE_Y        = 1,
    parameter int RD_TIMEOUT        = 255,
    localparam int NOC_BUS_SIZE     = WB_NOC_DATA_WIDTH + 6 + 2*SOC_SIZE_X + 2*SOC_SIZE_Y
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic                         wb_cyc_i,
    input  logic                         wb_stb_i,
    input  logic [WB_ADDR_WIDTH-1:0]     wb_adr_i,
    input  logic [3:0]                   wb_sel_i,
    input  logic                         wb_we_i,
    input  logic [WB_NOC_DATA_WIDTH-1:0] wb_dat_i,
    output logic [WB_NOC_DATA_WIDTH-1:0] wb_dat_o,
    output logic                         wb_ack_o,
    output logic                         wb_err_o,
    output logic [NOC_BUS_SIZE-1:0]      noc_din_o,
    output logic                         noc_wr_o,
    output logic                         noc_rd_o,
    input  logic [NOC_BUS_SIZE-1:0]      noc_dout_i,
    input  logic                         noc_wait_i,
    input  logic                         noc_nd_i
);

    localparam int DW   = WB_NOC_DATA_WIDTH;
    localparam int AW   = WB_ADDR_WIDTH;
    localparam int SX   = SOC_SIZE_X;
    localparam int SY   = SOC_SIZE_Y;
    localparam int OW   = SX + SY + 3;
    localparam int TW   = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT + 1) : 1;

    localparam logic [SX-1:0] X_O = SX'(NOC_X);
    localparam logic [SY-1:0] Y_O = SY'(NOC_Y);
    localparam logic [2:0]    L_O = 3'(NOC_LOCAL_ADR);
    localparam logic [SX-1:0] X_T = SX'(NOC_X_TGT);
    localparam logic [SY-1:0] Y_T = SY'(NOC_Y_TGT);
    localparam logic [2:0]    L_T = 3'(NOC_LOCAL_ADR_TGT);
    localparam logic [OW-1:0] TGT_ORIGIN = {X_T, Y_T, L_T};
    localparam logic [TW-1:0] T_LAST     = TW'(RD_TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, TX_CMD, TX_DATA, RX_WAIT, ACK} state_t;

    state_t          state, state_n;
    logic            we_q, we_n;
    logic [DW-1:0]   dat_q, dat_n;
    logic [DW-1:0]   tx_data, tx_n;
    logic [DW-1:0]   rdat_n;
    logic [TW-1:0]   timer, timer_n;
    logic            ack_n, err_n, wr_n, rd_n;
    logic [DW-1:0]   cmd_word;
    logic            rx_match;

    // Destination fields of received flits are not needed: everything here is for us.
    logic unused_rx;
    assign unused_rx = ^{wb_sel_i, noc_dout_i[NOC_BUS_SIZE-OW-1:DW]};

    assign noc_din_o = {X_O, Y_O, L_O, X_T, Y_T, L_T, tx_data};
    assign rx_match  = (noc_dout_i[NOC_BUS_SIZE-1 -: OW] == TGT_ORIGIN);

    always_comb begin
        cmd_word            = '0;
        cmd_word[DW-1 -: 3] = wb_we_i ? 3'd0 : 3'd1;
        cmd_word[AW-1:0]    = wb_adr_i;
    end

    always_comb begin
        state_n = state;
        we_n    = we_q;
        dat_n   = dat_q;
        tx_n    = tx_data;
        timer_n = timer;
        rdat_n  = wb_dat_o;
        ack_n   = 1'b0;
        err_n   = 1'b0;
        wr_n    = 1'b0;
        rd_n    = 1'b0;
        case (state)
            IDLE: begin
                // The err cycle lands in IDLE while the master still holds stb; don't re-accept it.
                if (wb_cyc_i && wb_stb_i && !wb_err_o) begin
                    we_n    = wb_we_i;
                    dat_n   = wb_dat_i;
                    tx_n    = cmd_word;
                    state_n = TX_CMD;
                end else if (noc_nd_i && !noc_rd_o) begin
                    rd_n = 1'b1;
                end
            end
            TX_CMD: begin
                if (noc_wr_o) begin
                    if (we_q) begin
                        tx_n    = dat_q;
                        state_n = TX_DATA;
                    end else begin
                        timer_n = '0;
                        state_n = RX_WAIT;
                    end
                end else if (!noc_wait_i) begin
                    wr_n = 1'b1;
                end
            end
            TX_DATA: begin
                if (noc_wr_o) begin
                    ack_n   = 1'b1;
                    state_n = ACK;
                end else if (!noc_wait_i) begin
                    wr_n = 1'b1;
                end
            end
            RX_WAIT: begin
                timer_n = timer + TW'(1);
                if (noc_nd_i && !noc_rd_o) begin
                    rd_n = 1'b1;
                    if (rx_match) begin
                        rdat_n  = noc_dout_i[DW-1:0];
                        ack_n   = 1'b1;
                        state_n = ACK;
                    end
                end
                // A matching response in the same cycle beats the timeout.
                if (state_n == RX_WAIT && timer == T_LAST) begin
                    rdat_n  = '0;
                    err_n   = 1'b1;
                    state_n = IDLE;
                end
            end
            ACK: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state    <= IDLE;
            we_q     <= 1'b0;
            dat_q    <= '0;
            tx_data  <= '0;
            timer    <= '0;
            wb_dat_o <= '0;
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            noc_wr_o <= 1'b0;
            noc_rd_o <= 1'b0;
        end else begin
            state    <= state_n;
            we_q     <= we_n;
            dat_q    <= dat_n;
            tx_data  <= tx_n;
            timer    <= timer_n;
            wb_dat_o <= rdat_n;
            wb_ack_o <= ack_n;
            wb_err_o <= err_n;
            noc_wr_o <= wr_n;
            noc_rd_o <= rd_n;
        end
    end

endmodule

// File: tb/tb_wishbone_slave_to_rtsnoc.sv
// Bench for wishbone_slave_to_rtsnoc: table of bus transfers with a flit scoreboard,
// a remote responder, and hand sequences for drain, foreign flits, timeout and reset.
module tb_wishbone_slave_to_rtsnoc;

    localparam int AW = 6;
    localparam int DW = 32;
    localparam int NB = DW + 6 + 4;
    localparam int TO = 16;

    typedef logic [NB-1:0] flit_t;

    // this node: X=0 Y=1 L=2 ; remote: X=1 Y=0 L=5
    localparam logic [9:0] HDR  = {1'b0, 1'b1, 3'd2, 1'b1, 1'b0, 3'd5};
    localparam logic [9:0] RHDR = {1'b1, 1'b0, 3'd5, 1'b0, 1'b1, 3'd2};
    localparam logic [9:0] FHDR = {1'b1, 1'b1, 3'd5, 1'b0, 1'b1, 3'd2};

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [AW-1:0] adr = '0;
    logic [3:0]    sel = 4'hF;
    logic [DW-1:0] wdat = '0;
    logic [DW-1:0] wb_dat_o;
    logic          wb_ack_o, wb_err_o;
    flit_t         noc_din_o;
    logic          noc_wr_o, noc_rd_o;
    flit_t         noc_dout = '0;
    logic          noc_wait = 1'b0;
    logic          noc_nd = 1'b0;

    wishbone_slave_to_rtsnoc #(
        .WB_ADDR_WIDTH(AW), .WB_NOC_DATA_WIDTH(DW),
        .NOC_LOCAL_ADR(2), .NOC_X(0), .NOC_Y(1),
        .NOC_LOCAL_ADR_TGT(5), .NOC_X_TGT(1), .NOC_Y_TGT(0),
        .SOC_SIZE_X(1), .SOC_SIZE_Y(1), .RD_TIMEOUT(TO)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_adr_i(adr), .wb_sel_i(sel),
        .wb_we_i(we), .wb_dat_i(wdat), .wb_dat_o(wb_dat_o),
        .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
        .noc_din_o(noc_din_o), .noc_wr_o(noc_wr_o), .noc_rd_o(noc_rd_o),
        .noc_dout_i(noc_dout), .noc_wait_i(noc_wait), .noc_nd_i(noc_nd)
    );

    always #5 clk = ~clk;

    int    total = 0, bad = 0;
    int    wr_cnt = 0, rd_cnt = 0, ack_cnt = 0, err_cnt = 0;
    int    cyc_n = 0, cmd_cyc = 0, err_cyc = 0;
    flit_t exp_q[$];
    flit_t rsp_q[$];
    flit_t ef;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] cmdw(input logic w, input logic [AW-1:0] a);
        logic [DW-1:0] c;
        c = '0;
        c[DW-1 -: 3] = w ? 3'd0 : 3'd1;
        c[AW-1:0] = a;
        return c;
    endfunction

    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Flit scoreboard and pulse counters.
    always @(negedge clk) begin
        if (rst_n) begin
            if (noc_wr_o) begin
                wr_cnt++;
                if (noc_din_o[DW-1 -: 3] == 3'd1) cmd_cyc = cyc_n;
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL flit_unexpected: got %h expected none", noc_din_o);
                end else begin
                    ef = exp_q.pop_front();
                    check("flit", noc_din_o, ef);
                end
            end
            if (noc_rd_o) rd_cnt++;
            if (wb_ack_o) ack_cnt++;
            if (wb_err_o) begin err_cnt++; err_cyc = cyc_n; end
        end
    end

    // Remote bridge: answers a read command with the queued flits, one pop at a time.
    initial begin : responder
        logic got;
        forever begin
            @(negedge clk);
            if (rst_n && noc_wr_o && noc_din_o[DW-1 -: 3] == 3'd1 && rsp_q.size() > 0) begin
                repeat (3) @(negedge clk);
                while (rsp_q.size() > 0) begin
                    noc_dout = rsp_q.pop_front();
                    noc_nd = 1'b1;
                    got = 1'b0;
                    for (int i = 0; i < 40 && !got; i++) begin
                        @(negedge clk);
                        if (noc_rd_o) got = 1'b1;
                    end
                    check("rsp_popped", got, 1'b1);
                end
                noc_nd = 1'b0;
            end
        end
    end

    task automatic wb_req(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input int budget, output logic ga, output logic ge,
                          output logic [DW-1:0] rd);
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d;
        ga = 1'b0; ge = 1'b0; rd = '0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (wb_ack_o || wb_err_o) begin
                ga = wb_ack_o; ge = wb_err_o; rd = wb_dat_o;
                break;
            end
        end
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    typedef struct {
        logic          we;
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
        logic [DW-1:0] rsp;
        int            wait_cyc;
    } vec_t;

    logic [DW-1:0] last_rd = '0;

    task automatic run_vec(input vec_t v);
        int w0, r0, a0, e0;
        logic ga, ge;
        logic [DW-1:0] rd;
        w0 = wr_cnt; r0 = rd_cnt; a0 = ack_cnt; e0 = err_cnt;
        exp_q.push_back({HDR, cmdw(v.we, v.adr)});
        if (v.we) exp_q.push_back({HDR, v.dat});
        else      rsp_q.push_back({RHDR, v.rsp});
        noc_wait = (v.wait_cyc != 0);
        fork
            wb_req(v.we, v.adr, v.dat, 200, ga, ge, rd);
            begin
                if (v.wait_cyc != 0) begin
                    repeat (v.wait_cyc) @(negedge clk);
                    check("no_wr_while_wait", 64'(wr_cnt - w0), 64'd0);
                    noc_wait = 1'b0;
                end
            end
        join
        repeat (3) @(negedge clk);
        check("ack_seen", ga, 1'b1);
        check("no_err", 64'(err_cnt - e0), 64'd0);
        check("one_ack_cycle", 64'(ack_cnt - a0), 64'd1);
        check("flit_count", 64'(wr_cnt - w0), v.we ? 64'd2 : 64'd1);
        check("rd_pulses", 64'(rd_cnt - r0), v.we ? 64'd0 : 64'd1);
        check("all_flits_sent", 64'(exp_q.size()), 64'd0);
        if (!v.we) begin
            check("rdata", rd, v.rsp);
            last_rd = v.rsp;
        end
        check("dat_hold", wb_dat_o, last_rd);
    endtask

    vec_t vecs[5];

    initial begin : main
        int w0, r0, a0, e0, d;
        logic ga, ge, got;
        logic [DW-1:0] rd;

        vecs[0] = '{we: 1'b1, adr: 6'h05, dat: 32'hDEADBEEF, rsp: 32'h0,         wait_cyc: 0};
        vecs[1] = '{we: 1'b0, adr: 6'h3F, dat: 32'h0,         rsp: 32'h12345678, wait_cyc: 0};
        vecs[2] = '{we: 1'b1, adr: 6'h2A, dat: 32'hCAFEF00D, rsp: 32'h0,         wait_cyc: 10};
        vecs[3] = '{we: 1'b0, adr: 6'h00, dat: 32'h0,         rsp: 32'hA5A50F0F, wait_cyc: 0};
        vecs[4] = '{we: 1'b1, adr: 6'h3F, dat: 32'hFFFFFFFF, rsp: 32'h0,         wait_cyc: 0};

        repeat (3) @(negedge clk);
        check("rst_ack", wb_ack_o, 1'b0);
        check("rst_err", wb_err_o, 1'b0);
        check("rst_wr", noc_wr_o, 1'b0);
        check("rst_rd", noc_rd_o, 1'b0);
        check("rst_dat", wb_dat_o, 32'h0);
        check("rst_din", noc_din_o, {HDR, 32'h0});
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Unsolicited flit in IDLE, left stale for one extra cycle: must pop exactly once.
        r0 = rd_cnt;
        noc_dout = {FHDR, 32'h0BADF00D};
        noc_nd = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (noc_rd_o) got = 1'b1;
        end
        @(negedge clk);
        noc_nd = 1'b0;
        repeat (3) @(negedge clk);
        check("drain_single_pop", 64'(rd_cnt - r0), 64'd1);
        check("drain_keeps_dat", wb_dat_o, last_rd);

        // Foreign-origin flit ahead of the real response.
        r0 = rd_cnt; a0 = ack_cnt;
        exp_q.push_back({HDR, cmdw(1'b0, 6'h11)});
        rsp_q.push_back({FHDR, 32'h11111111});
        rsp_q.push_back({RHDR, 32'h87654321});
        wb_req(1'b0, 6'h11, '0, 200, ga, ge, rd);
        repeat (3) @(negedge clk);
        check("foreign_ack", ga, 1'b1);
        check("foreign_rdata", rd, 32'h87654321);
        check("foreign_pops", 64'(rd_cnt - r0), 64'd2);
        check("foreign_one_ack", 64'(ack_cnt - a0), 64'd1);
        last_rd = 32'h87654321;

        // Read with no response: timeout error.
        a0 = ack_cnt; e0 = err_cnt;
        exp_q.push_back({HDR, cmdw(1'b0, 6'h22)});
        wb_req(1'b0, 6'h22, '0, 60, ga, ge, rd);
        repeat (3) @(negedge clk);
        check("to_err", ge, 1'b1);
        check("to_no_ack", 64'(ack_cnt - a0), 64'd0);
        check("to_one_err", 64'(err_cnt - e0), 64'd1);
        d = err_cyc - cmd_cyc;
        check("to_latency", (d >= TO && d <= TO + 1), 1'b1);
        check("to_dat_zero", wb_dat_o, 32'h0);
        last_rd = '0;
        run_vec('{we: 1'b1, adr: 6'h01, dat: 32'h00C0FFEE, rsp: 32'h0, wait_cyc: 0});

        // Asynchronous reset in the middle of RX_WAIT.
        a0 = ack_cnt; e0 = err_cnt; w0 = wr_cnt;
        exp_q.push_back({HDR, cmdw(1'b0, 6'h33)});
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 6'h33;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (wr_cnt != w0) got = 1'b1;
        end
        check("rst_test_cmd_sent", got, 1'b1);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_ack", wb_ack_o, 1'b0);
        check("arst_err", wb_err_o, 1'b0);
        check("arst_wr", noc_wr_o, 1'b0);
        check("arst_rd", noc_rd_o, 1'b0);
        check("arst_din", noc_din_o, {HDR, 32'h0});
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("arst_no_ack", 64'(ack_cnt - a0), 64'd0);
        check("arst_no_err", 64'(err_cnt - e0), 64'd0);
        check("arst_no_flits", 64'(wr_cnt - w0), 64'd1);
        last_rd = '0;
        run_vec('{we: 1'b1, adr: 6'h07, dat: 32'h13579BDF, rsp: 32'h0, wait_cyc: 0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
